// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and FSM state type shared by the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLK_PER_BIT_DEFAULT = 10_417;
    localparam int c_DATA_BITS         = 8;
    localparam int c_STOP_BITS         = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead read data and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full    = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : UART 8N1 transmitter fed from a small byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam int                  c_BAUD_W     = $clog2(CLK_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST  = c_BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_PRE   = c_BAUD_W'(CLK_PER_BIT - 2);
    localparam logic [2:0]          c_LAST_BIT   = 3'(c_DATA_BITS - 1);

    tx_state_t           r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shreg;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [7:0]          w_fifo_data;
    logic                w_bit_end;
    logic                w_pop;

    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    // Pop exactly where a frame begins: from IDLE, or chained at the stop-bit end.
    assign w_pop      = !w_fifo_empty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
    assign tx_ready_o = !w_fifo_full;
    assign tx_o       = r_tx;
    assign tx_busy_o  = r_busy;
    assign tx_done_o  = r_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (tx_valid_i),
        .i_pop     (w_pop),
        .i_wr_data (tx_data_i),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_shreg   <= w_fifo_data;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shreg[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shreg   <= {1'b0, r_shreg[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shreg[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    // Registered one clock early so the pulse lands on the last stop clock.
                    if (r_baud == c_BAUD_PRE) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (!w_fifo_empty) begin
                            r_shreg   <= w_fifo_data;
                            r_bit_idx <= '0;
                            r_tx      <= 1'b0;
                            r_state   <= START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_byte_tx
// Description : Self-checking bench for uart_byte_tx with a serial receiver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx;

    localparam int CPB        = 4;
    localparam int DEPTH      = 4;
    localparam int FRAME_CLKS = 10 * CPB;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_line;
    logic       tx_busy;
    logic       tx_done;

    logic [7:0] d_data   = 8'h00;
    logic       d_valid  = 1'b0;
    logic       d_ready;
    logic       d_tx;
    logic       d_busy;
    logic       d_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    uart_byte_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_o       (tx_line),
        .tx_busy_o  (tx_busy),
        .tx_done_o  (tx_done)
    );

    uart_byte_tx dut_default (
        .clk        (clk),
        .rst        (rst),
        .tx_data_i  (d_data),
        .tx_valid_i (d_valid),
        .tx_ready_o (d_ready),
        .tx_o       (d_tx),
        .tx_busy_o  (d_busy),
        .tx_done_o  (d_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    int done_q[$];
    always @(negedge clk) begin
        if (tx_done) done_q.push_back(cyc);
    end

    // Receiver model: start detected on first low sample, each bit sampled mid-period.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh   = 8'h00;
    bit         rx_act  = 1'b0;
    int         rx_c    = 0;
    int         rx_ferr = 0;
    always @(negedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (tx_line == 1'b0) begin
                rx_act <= 1'b1;
                rx_c   <= 1;
            end
        end else begin
            rx_c <= rx_c + 1;
            if (((rx_c + 1) % CPB) == CPB / 2) begin
                if ((rx_c + 1) / CPB == 0) begin
                    if (tx_line != 1'b0) rx_ferr <= rx_ferr + 1;
                end else if ((rx_c + 1) / CPB <= 8) begin
                    rx_sh[(rx_c + 1) / CPB - 1] <= tx_line;
                end else begin
                    if (tx_line != 1'b1) rx_ferr <= rx_ferr + 1;
                    rx_q.push_back(rx_sh);
                    rx_act <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rx(input string name, input logic [7:0] exp);
        if (rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no byte decoded, expected %0h", name, exp);
        end else begin
            chk(name, rx_q.pop_front(), exp);
        end
    endtask

    // Caller is positioned on the first start-bit clock; bits[] lists line levels in time order.
    task automatic check_frames(input logic [19:0] bits, input int nframes);
        for (int k = 0; k < nframes * FRAME_CLKS; k++) begin
            chk("tx_line", tx_line, bits[k / CPB]);
            chk("tx_done", tx_done, (k % FRAME_CLKS) == FRAME_CLKS - 1);
            chk("tx_busy", tx_busy, 1);
            tick();
        end
        chk("line_idle_after", tx_line, 1);
        chk("busy_clear_after", tx_busy, 0);
        chk("done_clear_after", tx_done, 0);
    endtask

    task automatic send_one(input logic [7:0] d, input logic [9:0] frame);
        rx_q.delete();
        chk("ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("line_high_accept_cycle", tx_line, 1);
        chk("busy_low_accept_cycle", tx_busy, 0);
        tick();
        check_frames({10'b0, frame}, 1);
        chk_rx("rx_byte", d);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        int   guard;
        logic rdy;

        // frame bit order (LSB = first on the line): start, d0..d7, stop
        vecs[0] = '{8'h41, 10'b1_0100_0001_0};
        vecs[1] = '{8'hFF, 10'b1_1111_1111_0};
        vecs[2] = '{8'h00, 10'b1_0000_0000_0};
        vecs[3] = '{8'h5A, 10'b1_0101_1010_0};
        vecs[4] = '{8'h80, 10'b1_1000_0000_0};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_ready", tx_ready, 1);
        chk("reset_tx", tx_line, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_default_ready", d_ready, 1);
        chk("reset_default_tx", d_tx, 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            send_one(vecs[i].data, vecs[i].frame);
        end

        // 0xFF then 0x00 chained with no idle gap
        rx_q.delete();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_data  = 8'h00;
        tick();
        tx_valid = 1'b0;
        check_frames({10'b1_0000_0000_0, 10'b1_1111_1111_0}, 2);
        chk_rx("rx_ff", 8'hFF);
        chk_rx("rx_00", 8'h00);

        // Six bytes with valid held high
        done_q.delete();
        rx_q.delete();
        acc      = 0;
        guard    = 0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        while (acc < 6 && guard < 400) begin
            rdy = tx_ready;
            tick();
            guard++;
            if (rdy) begin
                acc++;
                if (acc == 5) begin
                    chk("five_accepted_no_stall", guard, 5);
                    chk("ready_low_after_5th", tx_ready, 0);
                end
                tx_data = tx_data + 8'h01;
            end
        end
        tx_valid = 1'b0;
        chk("six_accepted", acc, 6);
        guard = 0;
        while (done_q.size() < 6 && guard < 400) begin
            tick();
            guard++;
        end
        chk("six_done_pulses", done_q.size(), 6);
        for (int i = 1; i < done_q.size(); i++) begin
            chk("done_spacing", done_q[i] - done_q[i-1], FRAME_CLKS);
        end
        for (int i = 0; i < 6; i++) begin
            chk_rx("rx_seq6", 8'(i));
        end
        tick();
        chk("busy_low_after_six", tx_busy, 0);

        // Reset in the middle of a 0xA5 frame with 0x77 still queued
        done_q.delete();
        rx_q.delete();
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_data  = 8'h77;
        tick();
        tx_valid = 1'b0;
        repeat (14) tick();
        chk("a5_clock15_level", tx_line, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_tx", tx_line, 1);
        chk("midreset_ready", tx_ready, 1);
        chk("midreset_busy", tx_busy, 0);
        chk("midreset_done", tx_done, 0);
        for (int i = 0; i < 12; i++) begin
            chk("flushed_line_idle", tx_line, 1);
            chk("flushed_busy", tx_busy, 0);
            tick();
        end
        chk("midreset_no_done", done_q.size(), 0);
        chk("midreset_no_rx", rx_q.size(), 0);
        send_one(8'h3C, 10'b1_0011_1100_0);

        // Push on the same edge as a pop with three entries queued
        rx_q.delete();
        tx_valid = 1'b1;
        tx_data  = 8'h10;
        tick();
        tx_data  = 8'h11;
        tick();
        tx_data  = 8'h12;
        tick();
        tx_data  = 8'h13;
        tick();
        tx_valid = 1'b0;
        guard = 0;
        while (!tx_done && guard < 100) begin
            tick();
            guard++;
        end
        chk("first_done_seen", tx_done, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h14;
        tick();
        tx_valid = 1'b0;
        chk("count_held_at_3", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h15;
        tick();
        tx_valid = 1'b0;
        chk("full_after_4th", tx_ready, 0);
        guard = 0;
        while (rx_q.size() < 6 && guard < 400) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 6; i++) begin
            chk_rx("rx_pushpop_order", 8'h10 + 8'(i));
        end
        guard = 0;
        while (tx_busy && guard < 100) begin
            tick();
            guard++;
        end
        chk("final_busy", tx_busy, 0);
        chk("framing_errors", rx_ferr, 0);
        chk("default_idle_tx", d_tx, 1);
        chk("default_idle_busy", d_busy, 0);
        chk("default_idle_done", d_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
